// File: rtl/axi_stall_bridge_if.sv
// CPU sram-like ports and single-beat AXI master channels of the stall bridge.
// The master modport is the bridge view; slave is the CPU/bus environment view.
interface axi_stall_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  // CPU instruction port
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_ok;

  // CPU data port
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_ok;

  logic              stallreq_axi;

  // AXI read channels
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arsize;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;
  logic [3:0]        rid_last;

  // AXI write channels
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awsize;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    input  inst_req, inst_addr, data_req, data_wr, data_size, data_wstrb,
           data_addr, data_wdata,
    output inst_rdata, inst_ok, data_rdata, data_ok, stallreq_axi,
    output arid, araddr, arsize, arvalid, rready, rid_last,
    input  arready, rid, rdata, rvalid,
    output awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bvalid
  );

  modport slave (
    output inst_req, inst_addr, data_req, data_wr, data_size, data_wstrb,
           data_addr, data_wdata,
    input  inst_rdata, inst_ok, data_rdata, data_ok, stallreq_axi,
    input  arid, araddr, arsize, arvalid, rready, rid_last,
    output arready, rid, rdata, rvalid,
    input  awaddr, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/axi_stall_bridge.sv
// Single-beat AXI master bridging CPU sram-like inst/data ports; stalls the
// pipeline while a request is unfinished and holds results until it advances.
module axi_stall_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  axi_stall_bridge_if.master bus
);
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam logic [3:0]  ID_INST   = 4'd0;
  localparam logic [3:0]  ID_DATA   = 4'd1;
  localparam logic [2:0]  SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B}   w_state_t;

  r_state_t          r_state, r_state_d;
  w_state_t          w_state, w_state_d;

  logic              inst_done, inst_done_d;
  logic              data_done, data_done_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [3:0]        arid_q, arid_d;
  logic [2:0]        arsize_q, arsize_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [3:0]        rid_q, rid_d;

  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [2:0]        awsize_q, awsize_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;

  logic              stall_c;
  logic              load_cand_c;
  logic              inst_cand_c;
  logic              store_cand_c;
  logic              rd_data_busy_c;

  // Pipeline stall: any current request without a held result.
  assign stall_c = resetn & ((bus.inst_req & ~inst_done) | (bus.data_req & ~data_done));

  assign load_cand_c    = bus.data_req & ~bus.data_wr & ~data_done & (w_state == W_IDLE);
  assign inst_cand_c    = bus.inst_req & ~inst_done;
  assign rd_data_busy_c = (r_state != R_IDLE) & (arid_q == ID_DATA);
  assign store_cand_c   = bus.data_req & bus.data_wr & ~data_done & ~rd_data_busy_c;

  // Next-state and next-output logic for both channel FSMs and the done flags.
  always_comb begin
    r_state_d    = r_state;
    w_state_d    = w_state;
    inst_done_d  = inst_done;
    data_done_d  = data_done;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    araddr_d     = araddr_q;
    arid_d       = arid_q;
    arsize_d     = arsize_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rid_d        = rid_q;
    awaddr_d     = awaddr_q;
    awsize_d     = awsize_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;

    // Pipeline advances this cycle, so held results are consumed.
    if (!stall_c) begin
      inst_done_d = 1'b0;
      data_done_d = 1'b0;
    end

    unique case (r_state)
      R_IDLE: begin
        if (load_cand_c) begin
          araddr_d  = bus.data_addr;
          arid_d    = ID_DATA;
          arsize_d  = 3'(bus.data_size);
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end else if (inst_cand_c) begin
          araddr_d  = bus.inst_addr;
          arid_d    = ID_INST;
          arsize_d  = SIZE_WORD;
          arvalid_d = 1'b1;
          r_state_d = R_AR;
        end
      end
      R_AR: begin
        if (bus.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        // Result is routed by the issued id; rid is only kept for debug.
        if (bus.rvalid) begin
          rid_d     = bus.rid;
          rready_d  = 1'b0;
          r_state_d = R_IDLE;
          if (arid_q == ID_DATA) begin
            data_rdata_d = bus.rdata;
            data_done_d  = 1'b1;
          end else begin
            inst_rdata_d = bus.rdata;
            inst_done_d  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    unique case (w_state)
      W_IDLE: begin
        if (store_cand_c) begin
          awaddr_d  = bus.data_addr;
          awsize_d  = 3'(bus.data_size);
          wdata_d   = bus.data_wdata;
          wstrb_d   = bus.data_wstrb;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          w_state_d = W_REQ;
        end
      end
      W_REQ: begin
        // AW and W complete independently; move on once both are done.
        awvalid_d = awvalid_q & ~bus.awready;
        wvalid_d  = wvalid_q & ~bus.wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d  = 1'b1;
          w_state_d = W_B;
        end
      end
      W_B: begin
        if (bus.bvalid) begin
          bready_d    = 1'b0;
          data_done_d = 1'b1;
          w_state_d   = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= R_IDLE;
      w_state      <= W_IDLE;
      inst_done    <= 1'b0;
      data_done    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      araddr_q     <= '0;
      arid_q       <= '0;
      arsize_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rid_q        <= '0;
      awaddr_q     <= '0;
      awsize_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
    end else begin
      r_state      <= r_state_d;
      w_state      <= w_state_d;
      inst_done    <= inst_done_d;
      data_done    <= data_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      araddr_q     <= araddr_d;
      arid_q       <= arid_d;
      arsize_q     <= arsize_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rid_q        <= rid_d;
      awaddr_q     <= awaddr_d;
      awsize_q     <= awsize_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
    end
  end

  assign bus.inst_ok      = inst_done;
  assign bus.data_ok      = data_done;
  assign bus.inst_rdata   = inst_rdata_q;
  assign bus.data_rdata   = data_rdata_q;
  assign bus.stallreq_axi = stall_c;
  assign bus.arid         = arid_q;
  assign bus.araddr       = araddr_q;
  assign bus.arsize       = arsize_q;
  assign bus.arvalid      = arvalid_q;
  assign bus.rready       = rready_q;
  assign bus.rid_last     = rid_q;
  assign bus.awaddr       = awaddr_q;
  assign bus.awsize       = awsize_q;
  assign bus.awvalid      = awvalid_q;
  assign bus.wdata        = wdata_q;
  assign bus.wstrb        = wstrb_q;
  assign bus.wlast        = 1'b1;
  assign bus.wvalid       = wvalid_q;
  assign bus.bready       = bready_q;
endmodule

// File: doc/axi_stall_bridge.md
Name: axi_stall_bridge

Overview:
- Single-beat AXI master that sits between the CPU's sram-like instruction/data ports and the system AXI bus.
- It is the source of the stallreq_axi input consumed by the pipeline controller. It holds stallreq_axi high while any current-cycle CPU memory request is unfinished.
- It latches completed results until the pipeline advances.
- One outstanding read and one outstanding write, at most.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low
- inst_req  in  1  fetch request; held while stalled
- inst_addr  in  ADDR_W  fetch address
- inst_rdata  out  DATA_W  fetch data; valid while inst_ok
- inst_ok  out  1  fetch complete, result held
- data_req  in  1  load/store request; held while stalled
- data_wr  in  1  1=store, 0=load
- data_size  in  2  AXI size code (0/1/2)
- data_wstrb  in  DATA_W/8  store byte enables
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_rdata  out  DATA_W  load data; valid while data_ok
- data_ok  out  1  load/store complete, result held
- stallreq_axi  out  1  to pipeline controller
- arid  out  4  0=inst, 1=data
- araddr  out  ADDR_W
- arsize  out  3
- arvalid  out  1
- arready  in  1
- rid  in  4
- rdata  in  DATA_W
- rvalid  in  1
- rready  out  1
- awaddr  out  ADDR_W
- awsize  out  3
- awvalid  out  1
- awready  in  1
- wdata  out  DATA_W
- wstrb  out  DATA_W/8
- wlast  out  1  constant 1
- wvalid  out  1
- wready  in  1
- bvalid  in  1
- bready  out  1

Behaviour:
- Reset (resetn=0, async): all FSMs go idle. All valid/ready outputs, inst_ok, data_ok and stallreq_axi are 0. Address/data registers are 0. Any in-flight AXI transaction is abandoned, because the system reset is global.
- Flags inst_done and data_done drive inst_ok and data_ok directly.
- stallreq_axi = (inst_req & ~inst_done) | (data_req & ~data_done), combinational from registers and inputs.
- Done flags clear at the clock edge where stallreq_axi==0, because the pipeline advances that cycle. A request present in that same cycle is a new request and is eligible for issue on the next cycle.
- Read FSM (R_IDLE, R_AR, R_WAIT):
  - In R_IDLE, candidates are a data load (data_req & ~data_wr & ~data_done & no write pending) and inst (inst_req & ~inst_done).
  - Data load has priority over inst.
  - On issue, register araddr, arid and arsize (inst uses size 2), then go to R_AR with arvalid=1.
- R_AR: hold arvalid and payload stable until arready. On arready go to R_WAIT, with arvalid=0 and rready=1.
- R_WAIT: on rvalid, latch rdata into inst_rdata or data_rdata according to the registered id, set the matching done flag, drop rready and return to R_IDLE. The rid mismatch is ignored; rid is registered for debug only.
- Write FSM (W_IDLE, W_REQ, W_B):
  - In W_IDLE, on data_req & data_wr & ~data_done & read FSM not serving a data load, register awaddr, awsize, wdata and wstrb. Then go to W_REQ with awvalid=1 and wvalid=1.
  - W_REQ: each valid drops independently on its own handshake, whether the AW and W handshakes occur in the same cycle or different cycles. Once both have completed, go to W_B with bready=1.
  - W_B: on bvalid, set data_done, drop bready and return to W_IDLE. bresp is ignored.
- An inst read may run concurrently with a data write.
- Latency: with arready and rvalid tied high, a read issues in cycle 0 (idle→R_AR). It is accepted in cycle 1 and data is latched at the end of cycle 2, so ok goes high in cycle 3.
- No new request is accepted on a channel whose done flag is set.

Test Plan:
- Reset while arvalid=1 in R_AR → arvalid=0, stallreq_axi=0 immediately, with no clock edge needed.
- inst_req=1, addr 0x1C000000, slave with zero-wait ready → arid=0, araddr=0x1C000000. stallreq_axi stays 1 until inst_ok. inst_rdata equals the returned data. The done flag clears one cycle after stallreq_axi falls.
- inst_req and data load (addr 0x80, size 2) asserted together → data AR issued first (arid=1). Inst AR follows after the R handshake. stallreq_axi falls only after both oks.
- Store addr 0x100, wdata 0xDEADBEEF, wstrb 0xF; awready is delayed 3 cycles and wready is immediate → wvalid drops after 1 cycle and awvalid after 4. bready rises afterwards, and data_ok rises after bvalid.
- Store concurrent with inst fetch → both AXI channels are active at once. stallreq_axi=1 until both complete, then one cycle of 0, then both done flags clear.
- Back-to-back fetches with inst_req held high across the advance cycle → the second AR issues the cycle after the done flag clears, with the new inst_addr.
